// File: rtl/game_pkg.sv
// Shared types and constants for the board animation path.
// Event codes mirror the values driven by the game controller.
package game_pkg;

    typedef enum logic [2:0] {
        A_IDLE,
        A_STEP,
        A_DONE,
        A_WAIT_EVT,
        A_EVT_BACK,
        A_EVT_HOLD,
        A_EVT_DONE,
        A_WIN
    } anim_state_t;

    localparam logic [3:0] EVT_NONE    = 4'd1;
    localparam logic [3:0] EVT_BANNER2 = 4'd2;
    localparam logic [3:0] EVT_BACK    = 4'd3;
    localparam logic [3:0] EVT_BANNER4 = 4'd4;
    localparam logic [3:0] EVT_BANNER6 = 4'd6;
    localparam logic [3:0] EVT_BANNER8 = 4'd8;
    localparam logic [3:0] EVT_WIN     = 4'd10;

    localparam int MAX_POS_DEFAULT = 10;

    function automatic logic [3:0] clamp_pos(input logic [3:0] pos, input logic [3:0] max_pos);
        return (pos > max_pos) ? max_pos : pos;
    endfunction

endpackage

// File: rtl/anim_tick_timer.sv
// Loadable down-counter; tc strobes while enabled at zero.
// The owner reloads on tc to get a periodic tick.
module anim_tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && (count != '0))
            count <= count - W'(1);
    end

    assign tc = en && (count == '0);

endmodule

// File: rtl/board_anim_sequencer.sv
// Animates pawn moves square by square and answers the controller's
// position/turn handshake with turn_done pulses.
//
// state      | meaning
// A_IDLE     | waiting for a pos_valid rise
// A_STEP     | stepping the mover toward its target
// A_DONE     | move finished, turn_done pulse
// A_WAIT_EVT | waiting for pos_valid low to read the event
// A_EVT_BACK | stepping the mover back to square 0
// A_EVT_HOLD | holding an event banner
// A_EVT_DONE | event finished, turn_done pulse
// A_WIN      | game over, frozen until reset
module board_anim_sequencer
    import game_pkg::*;
#(
    parameter int STEP_CYCLES = 25_000_000,
    parameter int EVT_CYCLES  = 100_000_000,
    parameter int MAX_POS     = MAX_POS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pos_valid,
    input  logic       turn,
    input  logic [3:0] p1_pos,
    input  logic [3:0] p2_pos,
    input  logic [3:0] event_flag,
    input  logic       winner_valid,
    input  logic       winner_id,
    output logic       turn_done,
    output logic [3:0] disp_p1_pos,
    output logic [3:0] disp_p2_pos,
    output logic       mover,
    output logic       anim_busy,
    output logic       event_active,
    output logic [3:0] event_code,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] debug_state
);

    localparam int MAX_CYC = (STEP_CYCLES > EVT_CYCLES) ? STEP_CYCLES : EVT_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TW-1:0] STEP_LOAD = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] EVT_LOAD  = TW'(EVT_CYCLES - 1);
    localparam logic [3:0]    MAX_SQ    = 4'(MAX_POS);

    anim_state_t   state, state_n;
    logic          pos_valid_d, rise;
    logic [3:0]    target, cur_disp, next_disp;
    logic          t_load, t_en, t_tc;
    logic [TW-1:0] t_val;
    logic          do_step, latch_move, latch_evt, latch_win, clear_target;

    assign rise      = pos_valid & ~pos_valid_d;
    assign cur_disp  = mover ? disp_p2_pos : disp_p1_pos;
    assign next_disp = clamp_pos((cur_disp < target) ? cur_disp + 4'd1 : cur_disp - 4'd1, MAX_SQ);

    anim_tick_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .en       (t_en),
        .tc       (t_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= A_IDLE;
            pos_valid_d <= 1'b0;
        end else begin
            state       <= state_n;
            pos_valid_d <= pos_valid;
        end
    end

    always_comb begin
        state_n      = state;
        t_load       = 1'b0;
        t_val        = STEP_LOAD;
        t_en         = 1'b0;
        do_step      = 1'b0;
        latch_move   = 1'b0;
        latch_evt    = 1'b0;
        latch_win    = 1'b0;
        clear_target = 1'b0;
        case (state)
            A_IDLE: begin
                if (rise) begin
                    latch_move = 1'b1;
                    t_load     = 1'b1;
                    state_n    = A_STEP;
                end
            end
            A_STEP, A_EVT_BACK: begin
                t_en = 1'b1;
                if (cur_disp == target) begin
                    state_n = (state == A_STEP) ? A_DONE : A_EVT_DONE;
                end else if (t_tc) begin
                    do_step = 1'b1;
                    t_load  = 1'b1;
                end
            end
            A_DONE: state_n = A_WAIT_EVT;
            // level check so a fall that happened mid-animation is not lost
            A_WAIT_EVT: begin
                if (!pos_valid) begin
                    latch_evt = 1'b1;
                    if (winner_valid) begin
                        latch_win = 1'b1;
                        state_n   = A_WIN;
                    end else if (event_flag == EVT_NONE) begin
                        state_n = A_IDLE;
                    end else if (event_flag == EVT_BACK) begin
                        clear_target = 1'b1;
                        t_load       = 1'b1;
                        state_n      = A_EVT_BACK;
                    end else begin
                        t_load  = 1'b1;
                        t_val   = EVT_LOAD;
                        state_n = A_EVT_HOLD;
                    end
                end
            end
            A_EVT_HOLD: begin
                t_en = 1'b1;
                if (t_tc) state_n = A_EVT_DONE;
            end
            A_EVT_DONE: state_n = A_IDLE;
            A_WIN:      state_n = A_WIN;
            default:    state_n = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mover       <= 1'b0;
            target      <= 4'd0;
            disp_p1_pos <= 4'd0;
            disp_p2_pos <= 4'd0;
            event_code  <= 4'd0;
            winner      <= 1'b0;
        end else begin
            if (latch_move) begin
                mover  <= turn;
                target <= clamp_pos(turn ? p2_pos : p1_pos, MAX_SQ);
            end
            if (clear_target) target <= 4'd0;
            if (latch_evt) event_code <= event_flag;
            if (latch_win) winner <= winner_id;
            if (do_step) begin
                if (mover) disp_p2_pos <= next_disp;
                else       disp_p1_pos <= next_disp;
            end
        end
    end

    assign turn_done    = (state == A_DONE) || (state == A_EVT_DONE);
    assign anim_busy    = (state != A_IDLE) && (state != A_WIN);
    assign event_active = (state == A_EVT_HOLD) || (state == A_EVT_BACK);
    assign game_over    = (state == A_WIN);
    assign debug_state  = state;

endmodule

// File: doc/board_anim_sequencer.md
Name: board_anim_sequencer

Overview:
- UI-side responder to the game controller's position/turn handshake. It consumes pos_valid, p1_pos, p2_pos, turn, event_flag and winner_valid.
- It animates each pawn's displayed square one square at a time and returns single-cycle turn_done pulses: one after each move, and one after each non-trivial event animation.
- Sits between the game controller and the board renderer/VGA overlay. Same clk domain as the controller.

Parameters:
- STEP_CYCLES, 25_000_000, clocks per one-square pawn move (0.25 s at 100 MHz).
- EVT_CYCLES, 100_000_000, clocks an event banner is held for events 2/4/6/8.
- MAX_POS, 10, last board square; targets are clamped to this value.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- pos_valid  in  1  level from controller: high from the move-update cycle until the event-check cycle.
- turn  in  1  current mover: 0 = player 1, 1 = player 2.
- p1_pos  in  4  controller position of player 1.
- p2_pos  in  4  controller position of player 2.
- event_flag  in  4  controller event code: 1 none, 2/4/6/8 banner, 3 back-to-start, 10 win.
- winner_valid  in  1  controller win flag.
- winner_id  in  1  0 = player 1, 1 = player 2.
- turn_done  out  1  one-cycle pulse: animation complete.
- disp_p1_pos  out  4  displayed square of player 1.
- disp_p2_pos  out  4  displayed square of player 2.
- mover  out  1  player currently being animated.
- anim_busy  out  1  high in any state except A_IDLE and A_WIN.
- event_active  out  1  high in A_EVT_HOLD and A_EVT_BACK.
- event_code  out  4  event_flag latched at pos_valid fall.
- game_over  out  1  high in A_WIN.
- winner  out  1  winner_id latched on entry to A_WIN.
- debug_state  out  3  encoded FSM state.

Behaviour:
- Reset values: all outputs 0; state A_IDLE; timer 0; pos_valid_d 0.
- Edge detection uses pos_valid_d, a registered copy of pos_valid.
  - rise = pos_valid & ~pos_valid_d
  - fall = ~pos_valid & pos_valid_d
- A_IDLE:
  - On rise, latch mover = turn and target = min(turn ? p2_pos : p1_pos, MAX_POS).
  - Clear the timer and go to A_STEP.
  - A fall seen in A_IDLE is ignored.
- A_STEP:
  - The timer counts 0..STEP_CYCLES-1.
  - At terminal count, the mover's disp_* moves one square toward target (+1 if below, -1 if above) and the timer clears.
  - When the mover's disp equals target, go to A_DONE. A zero-distance move therefore reaches A_DONE the cycle after entry.
- A_DONE:
  - turn_done = 1 for exactly this one cycle.
  - Next state is A_WAIT_EVT.
- A_WAIT_EVT: when pos_valid is low (level check, which covers a fall that occurred early), latch event_code = event_flag, then branch:
  - winner_valid = 1 → A_WIN; latch winner; no pulse.
  - event_flag == 1 → A_IDLE; no pulse.
  - event_flag == 3 → A_EVT_BACK; target = 0; timer cleared.
  - otherwise → A_EVT_HOLD; timer cleared.
- A_EVT_BACK: same stepping as A_STEP, but downward to 0. When the mover's disp reaches 0, go to A_EVT_DONE.
- A_EVT_HOLD: count EVT_CYCLES, then go to A_EVT_DONE.
- A_EVT_DONE: turn_done = 1 for one cycle, then A_IDLE.
- A_WIN:
  - Terminal state; game_over = 1; disp_* hold.
  - Exited only by reset.
  - Rises on pos_valid are ignored.
- Only the mover's disp_* register changes during an animation. The other pawn holds its value.
- Rises on pos_valid outside A_IDLE are ignored; no queuing.
- Arithmetic:
  - disp_* are 4-bit and saturate to the range 0..MAX_POS.
  - Timer width = $clog2(max(STEP_CYCLES, EVT_CYCLES)).
- Asynchronous reset at any point forces A_IDLE and all outputs to 0. No pulse is emitted.
- Exactly two turn_done pulses per turn with an event other than 1 or 10; exactly one pulse otherwise.

Decomposition:
- Shared package game_pkg:
  - anim_state_t enum: A_IDLE, A_STEP, A_DONE, A_WAIT_EVT, A_EVT_BACK, A_EVT_HOLD, A_EVT_DONE, A_WIN.
  - Event code constants: EVT_NONE=1, EVT_BANNER2=2, EVT_BACK=3, EVT_BANNER4=4, EVT_BANNER6=6, EVT_BANNER8=8, EVT_WIN=10.
  - MAX_POS default.
- One sub-module, anim_tick_timer: loadable down-counter with a terminal-count strobe, reused for step and hold timing.

Test Plan:
All scenarios use STEP_CYCLES=4, EVT_CYCLES=8.
- Reset check: assert reset mid-simulation → all outputs 0 the same cycle; debug_state = A_IDLE.
- Plain move: turn=0, p1_pos 0→2, pos_valid rises → disp_p1_pos becomes 1 at entry+4 and 2 at entry+8; turn_done one cycle at entry+9; disp_p2_pos stays 0. Drop pos_valid with event_flag=1 → no second pulse; back to A_IDLE.
- Back-to-start: turn=1, p2_pos=3, pos_valid rises, then falls with event_flag=3 → disp_p2_pos steps 0→3, first pulse, then steps 3→2→1→0 at 4-cycle spacing, second pulse; event_code=3.
- Banner: move to square 4, then event_flag=4 → event_active high for 8 cycles, then one turn_done pulse.
- Win clamp: p1 disp at 9, p1_pos=10, pos_valid rises → one step to 10 and a pulse. pos_valid falls with winner_valid=1, winner_id=0 → game_over=1, winner=0, no further pulses; a later pos_valid rise is ignored.
- Reset mid-animation: assert reset while in A_STEP with disp_p1_pos=1 → disp_p1_pos=0, no turn_done; next rise animates from 0.
